// File: rtl/axi_master_wr_engine_if.sv
// Bus bundle for axi_master_wr_engine: command, user write-data, completion
// and the AXI AW/W/B channels. The master modport is the engine side.
interface axi_master_wr_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [3:0]              cmd_len;

    logic                    wd_valid;
    logic                    wd_ready;
    logic [DATA_WIDTH-1:0]   wd_data;
    logic [DATA_WIDTH/8-1:0] wd_strb;

    logic                    done;
    logic [1:0]              done_resp;

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [3:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len,
        input  wd_valid, wd_data, wd_strb,
        input  awready, wready, bresp, bvalid,
        output cmd_ready, wd_ready, done, done_resp,
        output awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len,
        output wd_valid, wd_data, wd_strb,
        output awready, wready, bresp, bvalid,
        input  cmd_ready, wd_ready, done, done_resp,
        input  awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready
    );
endinterface

// File: rtl/axi_master_wr_engine.sv
// Single-outstanding AXI write burst engine (IDLE -> ADDR -> DATA -> RESP).
// Define AXI_MASTER_WR_TIMEOUT_EN to abort a burst after 256 handshake-free cycles.
module axi_master_wr_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    axi_master_wr_engine_if.master bus
);
    localparam int         STRB_W = DATA_WIDTH / 8;
    localparam logic [2:0] AXSIZE = 3'($clog2(STRB_W));

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                state;
    logic                  cmd_ready_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  wlast_q;
    logic                  bready_q;
    logic                  done_q;
    logic [1:0]            done_resp_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [3:0]            awlen_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [4:0]            beat_cnt;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic wd_ready_c;
    logic wd_fire;

`ifdef AXI_MASTER_WR_TIMEOUT_EN
    logic [7:0] to_cnt;
`endif

    assign aw_hs = awvalid_q && bus.awready;
    assign w_hs  = wvalid_q && bus.wready;
    assign b_hs  = bready_q && bus.bvalid;

    // The output register is reloaded in the same cycle it drains, so a
    // continuous stream needs no bubble between beats.
    assign wd_ready_c = !areset && (state == DATA) &&
                        (beat_cnt <= {1'b0, awlen_q}) &&
                        (!wvalid_q || bus.wready);
    assign wd_fire    = bus.wd_valid && wd_ready_c;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            done_resp_q <= 2'b00;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            beat_cnt    <= '0;
`ifdef AXI_MASTER_WR_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_ready_q && bus.cmd_valid) begin
                        awaddr_q    <= bus.cmd_addr;
                        awlen_q     <= bus.cmd_len;
                        awvalid_q   <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        beat_cnt    <= '0;
                        state       <= ADDR;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ADDR: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (wd_fire) begin
                        wdata_q  <= bus.wd_data;
                        wstrb_q  <= bus.wd_strb;
                        wvalid_q <= 1'b1;
                        wlast_q  <= (beat_cnt[3:0] == awlen_q);
                        beat_cnt <= beat_cnt + 5'd1;
                    end else if (w_hs) begin
                        wvalid_q <= 1'b0;
                        wlast_q  <= 1'b0;
                    end
                    if (w_hs && wlast_q) begin
                        bready_q <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        bready_q    <= 1'b0;
                        done_q      <= 1'b1;
                        done_resp_q <= bus.bresp;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef AXI_MASTER_WR_TIMEOUT_EN
            // The 256th consecutive cycle without progress overrides the state step above.
            if (state == IDLE || aw_hs || w_hs || b_hs) begin
                to_cnt <= '0;
            end else if (to_cnt == 8'hFF) begin
                to_cnt      <= '0;
                awvalid_q   <= 1'b0;
                wvalid_q    <= 1'b0;
                wlast_q     <= 1'b0;
                bready_q    <= 1'b0;
                done_q      <= 1'b1;
                done_resp_q <= 2'b10;
                cmd_ready_q <= 1'b0;
                state       <= IDLE;
            end else begin
                to_cnt <= to_cnt + 8'd1;
            end
`endif
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.wd_ready  = wd_ready_c;
    assign bus.done      = done_q;
    assign bus.done_resp = done_resp_q;
    assign bus.awaddr    = awaddr_q;
    assign bus.awlen     = awlen_q;
    assign bus.awsize    = AXSIZE;
    assign bus.awburst   = 2'b01;
    assign bus.awvalid   = awvalid_q;
    assign bus.wdata     = wdata_q;
    assign bus.wstrb     = wstrb_q;
    assign bus.wlast     = wlast_q;
    assign bus.wvalid    = wvalid_q;
    assign bus.bready    = bready_q;
endmodule

// File: tb/tb_axi_master_wr_engine.sv
// Bench for axi_master_wr_engine: table of burst vectors driven cycle by cycle,
// W beats checked against a scoreboard queue, plus reset and timeout sequences.
module tb_axi_master_wr_engine;
    logic aclk;
    logic areset;

    axi_master_wr_engine_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    axi_master_wr_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus.master)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  bresp;
        int          aw_delay;
        int          b_delay;
        bit          wr_toggle;
        bit          wd_gaps;
        bit          b_noise;
        logic [31:0] d0;
        logic [3:0]  s0;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } beat_t;

    vec_t  vecs[6];
    beat_t sb[$];
    int    vectors    = 0;
    int    miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wd_valid  = 1'b0;
        bus.wd_data   = '0;
        bus.wd_strb   = '0;
        bus.awready   = 1'b0;
        bus.wready    = 1'b0;
        bus.bvalid    = 1'b0;
        bus.bresp     = 2'b00;
    endtask

    // Runs one burst; abort_beats > 0 returns right after that many W beats are consumed.
    task automatic run_burst(input vec_t v, input int abort_beats);
        int          cyc = 0, aw_wait = 0, b_wait = 0, sent = 0, got = 0;
        int          first_w = -1, last_w = -1;
        bit          cmd_sent = 0, aw_acc = 0, aw_prev;
        logic [31:0] cur_data = v.d0;
        logic [3:0]  cur_strb = v.s0;
        logic        p_awvalid = 0, p_awready = 0, p_wvalid = 0, p_wready = 0, p_wlast = 0;
        logic [31:0] p_awaddr = 0, p_wdata = 0;
        beat_t       exp_b;
        sb.delete();
        forever begin
            @(negedge aclk);
            cyc++;
            if (cyc > 400) begin
                vectors++; miscompares++;
                $display("FAIL burst_timeout: addr %0h got no done after 400 cycles", v.addr);
                idle_inputs();
                return;
            end
            if (bus.done) begin
                chk("done_resp", bus.done_resp, v.exp_resp);
                chk("beats_at_done", got, int'(v.len) + 1);
                chk("sb_empty_at_done", sb.size(), 0);
                if (!v.wr_toggle && !v.wd_gaps)
                    chk("w_back_to_back_span", last_w - first_w, int'(v.len));
                idle_inputs();
                @(negedge aclk);
                chk("done_one_cycle", bus.done, 0);
                chk("cmd_ready_after_done", bus.cmd_ready, 1);
                return;
            end
            if (p_awvalid && !p_awready) begin
                chk("aw_stall_valid", bus.awvalid, 1);
                chk("aw_stall_addr", bus.awaddr, p_awaddr);
            end
            if (p_wvalid && !p_wready) begin
                chk("w_stall_valid", bus.wvalid, 1);
                chk("w_stall_data", bus.wdata, p_wdata);
                chk("w_stall_last", bus.wlast, p_wlast);
            end
            if (bus.awvalid) begin
                chk("awaddr", bus.awaddr, v.addr);
                chk("awlen", bus.awlen, v.len);
                chk("awsize", bus.awsize, 3'd2);
                chk("awburst", bus.awburst, 2'b01);
            end
            if (bus.wvalid && !aw_acc) chk("w_before_aw", bus.wvalid, 0);

            bus.cmd_valid = !cmd_sent;
            bus.cmd_addr  = v.addr;
            bus.cmd_len   = v.len;
            bus.awready   = bus.awvalid && (aw_wait >= v.aw_delay);
            bus.wready    = v.wr_toggle ? (cyc % 2 == 1) : 1'b1;
            bus.wd_valid  = (sent <= int'(v.len)) && (!v.wd_gaps || (cyc % 2 == 0));
            bus.wd_data   = cur_data;
            bus.wd_strb   = cur_strb;
            bus.bvalid    = bus.bready ? (b_wait >= v.b_delay) : v.b_noise;
            bus.bresp     = bus.bready ? v.bresp : 2'b11;
            #1;
            aw_prev = aw_acc;
            if (bus.cmd_valid && bus.cmd_ready) cmd_sent = 1;
            if (bus.awvalid) begin
                if (bus.awready) aw_acc = 1;
                else aw_wait++;
            end
            if (!aw_prev && bus.wd_ready) chk("wd_ready_before_aw", bus.wd_ready, 0);
            if (bus.wd_valid && bus.wd_ready) begin
                sb.push_back('{data: cur_data, strb: cur_strb, last: (sent == int'(v.len))});
                sent++;
                cur_data = $urandom;
                cur_strb = 4'($urandom_range(0, 15));
            end
            if (bus.wvalid && bus.wready) begin
                if (sb.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL w_extra_beat: data %0h with empty scoreboard", bus.wdata);
                end else begin
                    exp_b = sb.pop_front();
                    chk("wdata", bus.wdata, exp_b.data);
                    chk("wstrb", bus.wstrb, exp_b.strb);
                    chk("wlast", bus.wlast, exp_b.last);
                end
                got++;
                if (first_w < 0) first_w = cyc;
                last_w = cyc;
            end
            if (bus.bready && !bus.bvalid) b_wait++;
            p_awvalid = bus.awvalid; p_awready = bus.awready; p_awaddr = bus.awaddr;
            p_wvalid = bus.wvalid; p_wready = bus.wready; p_wdata = bus.wdata; p_wlast = bus.wlast;
            if (abort_beats > 0 && got == abort_beats) return;
        end
    endtask

    initial begin
        vec_t rv;
        int   t0;
        bit   seen;
        vecs[0] = '{32'h0000_1000, 4'd0,  2'b00, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 4'hF, 2'b00};
        vecs[1] = '{32'h0000_2000, 4'd15, 2'b00, 0, 0, 0, 0, 0, 32'h0102_0304, 4'hF, 2'b00};
        vecs[2] = '{32'h0000_3040, 4'd7,  2'b00, 5, 0, 1, 0, 0, 32'hCAFE_0001, 4'h3, 2'b00};
        vecs[3] = '{32'h0000_4000, 4'd3,  2'b10, 0, 0, 0, 0, 0, 32'h1111_2222, 4'hF, 2'b10};
        vecs[4] = '{32'h0000_5000, 4'd2,  2'b01, 1, 3, 0, 1, 1, 32'h5555_AAAA, 4'h9, 2'b01};
        vecs[5] = '{32'h0000_6000, 4'd4,  2'b11, 2, 1, 1, 0, 0, 32'h7777_8888, 4'hC, 2'b11};

        idle_inputs();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_awvalid", bus.awvalid, 0);
        chk("rst_wvalid", bus.wvalid, 0);
        chk("rst_bready", bus.bready, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_done_resp", bus.done_resp, 0);
        chk("rst_awaddr", bus.awaddr, 0);
        chk("rst_awsize", bus.awsize, 3'd2);
        chk("rst_awburst", bus.awburst, 2'b01);
        areset = 1'b0;

        for (int i = 0; i < 6; i++) run_burst(vecs[i], 0);

        // Reset asserted mid-burst after the second of eight beats.
        rv = '{32'h0000_7000, 4'd7, 2'b00, 0, 0, 0, 0, 0, 32'h0BAD_F00D, 4'hF, 2'b00};
        run_burst(rv, 2);
        idle_inputs();
        areset = 1'b1;
        @(negedge aclk);
        chk("mid_rst_awvalid", bus.awvalid, 0);
        chk("mid_rst_wvalid", bus.wvalid, 0);
        chk("mid_rst_wlast", bus.wlast, 0);
        chk("mid_rst_bready", bus.bready, 0);
        chk("mid_rst_wdata", bus.wdata, 0);
        chk("mid_rst_wstrb", bus.wstrb, 0);
        chk("mid_rst_awlen", bus.awlen, 0);
        chk("mid_rst_cmd_ready", bus.cmd_ready, 0);
        areset = 1'b0;
        rv = '{32'h0000_8000, 4'd1, 2'b00, 0, 0, 0, 0, 0, 32'h1234_5678, 4'hA, 2'b00};
        run_burst(rv, 0);

        // AW never accepted: either the watchdog fires or the engine waits.
        t0 = -1;
        seen = 0;
        bus.cmd_addr = 32'h0000_9000;
        bus.cmd_len  = 4'd3;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge aclk);
            if (bus.awvalid && t0 < 0) t0 = c;
            if (bus.done) begin
                seen = 1;
`ifdef AXI_MASTER_WR_TIMEOUT_EN
                chk("timeout_latency", c - t0, 256);
                chk("timeout_resp", bus.done_resp, 2'b10);
                chk("timeout_awvalid", bus.awvalid, 0);
`else
                chk("no_timeout_done", bus.done, 0);
`endif
            end
`ifndef AXI_MASTER_WR_TIMEOUT_EN
            if (c == 300) begin
                chk("no_timeout_awvalid", bus.awvalid, 1);
                chk("no_timeout_awaddr", bus.awaddr, 32'h0000_9000);
                seen = 1;
            end
`endif
            bus.cmd_valid = bus.cmd_ready ? 1'b1 : 1'b0;
            if (t0 >= 0) bus.cmd_valid = 1'b0;
            bus.awready = 1'b0;
        end
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL timeout_seq: no done within 400 cycles");
        end
        idle_inputs();
`ifndef AXI_MASTER_WR_TIMEOUT_EN
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
`endif
        run_burst(vecs[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
